stream_frame_ctrl: RTL and testbench
====================================

Name: stream_frame_ctrl

Overview:
- Frame sequencer between the MM2S/S2MM AXI-Stream FIFO pair and the processing core.
- Waits until the MM2S FIFO holds a full input frame, then forwards exactly cfg_in_len words to the core.
- Concurrently collects exactly cfg_out_len result words from the core and pushes them into the S2MM FIFO, inserting tlast on the final word.
- Reports done, busy, error and frame-count status to the control register bank.

Parameters:
DATA_WIDTH, 16, stream data width (matches FIFO TDATA_WIDTH)
LEN_W, 10, width of frame-length registers and word counters (FIFO depth 512, WR_DATA_COUNT_WIDTH 10)
FCNT_W, 16, width of completed-frame counter

Ports:
aclk  in  1  single clock for all logic
areset  in  1  synchronous reset, active-high
cfg_start  in  1  one-cycle pulse, begin a frame
cfg_abort  in  1  one-cycle pulse, abandon the current frame
cfg_in_len  in  LEN_W  input words per frame, sampled on start
cfg_out_len  in  LEN_W  output words per frame, sampled on start
mm2s_tdata  in  DATA_WIDTH  MM2S FIFO read data
mm2s_tvalid  in  1  MM2S FIFO data valid
mm2s_tlast  in  1  MM2S FIFO tlast
mm2s_data_count  in  LEN_W  MM2S FIFO write data count
mm2s_tready  out  1  pop from MM2S FIFO
core_in_tdata  out  DATA_WIDTH  data to core
core_in_tvalid  out  1  valid to core
core_in_tlast  out  1  last input word of frame
core_in_tready  in  1  core accepts input
core_out_tdata  in  DATA_WIDTH  core result
core_out_tvalid  in  1  core result valid
core_out_tready  out  1  controller accepts result
s2mm_tdata  out  DATA_WIDTH  to S2MM FIFO
s2mm_tvalid  out  1  to S2MM FIFO
s2mm_tlast  out  1  last output word of frame
s2mm_tready  in  1  S2MM FIFO ready
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse on frame completion
err_cfg  out  1  one-cycle pulse, start rejected
err_tlast  out  1  sticky, input tlast mismatch; cleared on accepted start
frame_count  out  FCNT_W  completed frames, wraps

Behaviour:
- Reset: state IDLE. All outputs 0, including counters, registered lengths and sticky error.
- States: IDLE, WAIT_FILL, RUN, DONE.
- IDLE, cfg_start:
  - If either length is 0 or cfg_in_len > 512: pulse err_cfg next cycle and stay IDLE.
  - Otherwise latch both lengths, clear in_cnt, out_cnt and err_tlast, and go to WAIT_FILL.
  - cfg_start outside IDLE is ignored.
- WAIT_FILL: all ready/valid outputs 0. Go to RUN the cycle after mm2s_data_count >= in_len is sampled.
- RUN, input path (combinational passthrough, zero latency):
  - While in_cnt < in_len: core_in_tvalid = mm2s_tvalid; mm2s_tready = core_in_tready; core_in_tdata = mm2s_tdata; core_in_tlast = (in_cnt == in_len-1).
  - On handshake (mm2s_tvalid & core_in_tready), in_cnt increments.
  - Once in_cnt == in_len, the input path is gated: mm2s_tready = 0, core_in_tvalid = 0.
  - tlast check on each handshake: err_tlast is set if mm2s_tlast != (in_cnt == in_len-1).
  - A tlast mismatch never alters the count; the frame still consumes exactly in_len words.
- RUN, output path (combinational, runs concurrently with input):
  - While out_cnt < out_len: s2mm_tvalid = core_out_tvalid; core_out_tready = s2mm_tready; s2mm_tdata = core_out_tdata; s2mm_tlast = (out_cnt == out_len-1).
  - On handshake, out_cnt increments.
  - Once out_cnt == out_len, both sides are gated to 0; further core output is back-pressured.
- RUN to DONE: when both counters have reached their lengths, including when both final handshakes happen in the same cycle.
- DONE: lasts one cycle. done = 1, frame_count += 1, then IDLE.
- cfg_abort in WAIT_FILL or RUN:
  - Next cycle go to IDLE. All valid/ready outputs drop combinationally in the abort cycle itself, so there is no handshake in that cycle.
  - No done pulse, frame_count unchanged, FIFO contents untouched.
  - cfg_abort in IDLE or DONE is ignored; cfg_abort beats cfg_start.
- areset overrides everything, in any state, mid-frame included.
- All data and tlast are qualified by valid; data outputs are don't-care when valid is low.

Test Plan:
- Basic frame: start, in_len=8, out_len=4; preload 8 words 1..8 with tlast on 8 -> core receives 1..8 with core_in_tlast only on 8; S2MM receives 4 core words with tlast on 4th; done pulses once; frame_count=1; err_tlast=0.
- Fill wait: in_len=16 with only 10 words in FIFO -> stays WAIT_FILL, no mm2s_tready. Push 6 more -> enters RUN one cycle after count reads 16.
- Back-pressure: randomly toggle core_in_tready, core_out_tvalid and s2mm_tready at 50%; in_len=out_len=32 -> exactly 32 words each way, order preserved, no duplicates or drops, done once.
- tlast error: in_len=4, source tlast on word 2 -> 4 words forwarded, err_tlast=1 stays set; next valid start clears it.
- Config/abort: start with out_len=0 -> err_cfg pulse, stays IDLE. Abort mid-RUN after 3 of 8 words -> next cycle IDLE, busy=0, no done, frame_count unchanged.
- Reset mid-RUN: assert areset for one cycle -> all outputs 0 next cycle. A following start runs a full frame correctly.

Source files
------------

// File: rtl/stream_frame_ctrl.sv
// Frame sequencer between the MM2S/S2MM stream FIFOs and the processing core.
// Waits for a full input frame in the MM2S FIFO, forwards in_len words to the core,
// collects out_len result words into the S2MM FIFO with tlast on the final word.
module stream_frame_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W      = 10,
  parameter int FCNT_W     = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [LEN_W-1:0]      cfg_in_len,
  input  logic [LEN_W-1:0]      cfg_out_len,
  input  logic [DATA_WIDTH-1:0] mm2s_tdata,
  input  logic                  mm2s_tvalid,
  input  logic                  mm2s_tlast,
  input  logic [LEN_W-1:0]      mm2s_data_count,
  output logic                  mm2s_tready,
  output logic [DATA_WIDTH-1:0] core_in_tdata,
  output logic                  core_in_tvalid,
  output logic                  core_in_tlast,
  input  logic                  core_in_tready,
  input  logic [DATA_WIDTH-1:0] core_out_tdata,
  input  logic                  core_out_tvalid,
  output logic                  core_out_tready,
  output logic [DATA_WIDTH-1:0] s2mm_tdata,
  output logic                  s2mm_tvalid,
  output logic                  s2mm_tlast,
  input  logic                  s2mm_tready,
  output logic                  busy,
  output logic                  done,
  output logic                  err_cfg,
  output logic                  err_tlast,
  output logic [FCNT_W-1:0]     frame_count
);

  typedef enum logic [1:0] {IDLE, WAIT_FILL, RUN, DONE} state_t;

  // Largest input frame the MM2S FIFO can hold.
  localparam logic [LEN_W:0]    MAX_IN_LEN = (LEN_W+1)'(512);
  localparam logic [LEN_W-1:0]  LEN_ONE    = LEN_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_ONE   = FCNT_W'(1);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    in_len_q, in_len_d;
  logic [LEN_W-1:0]    out_len_q, out_len_d;
  logic [LEN_W-1:0]    in_cnt_q, in_cnt_d;
  logic [LEN_W-1:0]    out_cnt_q, out_cnt_d;
  logic                err_tlast_q, err_tlast_d;
  logic                err_cfg_q, err_cfg_d;
  logic [FCNT_W-1:0]   frame_count_q, frame_count_d;
  logic                in_last;
  logic                out_last;

  // Next-state, counters and the gated stream passthroughs.
  always_comb begin
    state_d         = state_q;
    in_len_d        = in_len_q;
    out_len_d       = out_len_q;
    in_cnt_d        = in_cnt_q;
    out_cnt_d       = out_cnt_q;
    err_tlast_d     = err_tlast_q;
    err_cfg_d       = 1'b0;
    frame_count_d   = frame_count_q;
    in_last         = 1'b0;
    out_last        = 1'b0;
    mm2s_tready     = 1'b0;
    core_in_tvalid  = 1'b0;
    core_in_tdata   = '0;
    core_in_tlast   = 1'b0;
    core_out_tready = 1'b0;
    s2mm_tvalid     = 1'b0;
    s2mm_tdata      = '0;
    s2mm_tlast      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_in_len == '0 || cfg_out_len == '0 || {1'b0, cfg_in_len} > MAX_IN_LEN) begin
            err_cfg_d = 1'b1;
          end else begin
            in_len_d    = cfg_in_len;
            out_len_d   = cfg_out_len;
            in_cnt_d    = '0;
            out_cnt_d   = '0;
            err_tlast_d = 1'b0;
            state_d     = WAIT_FILL;
          end
        end
      end
      WAIT_FILL: begin
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (mm2s_data_count >= in_len_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort drops every valid/ready in the same cycle so no word moves.
        if (cfg_abort) begin
          state_d = IDLE;
        end else begin
          if (in_cnt_q < in_len_q) begin
            in_last        = (in_cnt_q == in_len_q - LEN_ONE);
            core_in_tvalid = mm2s_tvalid;
            mm2s_tready    = core_in_tready;
            core_in_tdata  = mm2s_tdata;
            core_in_tlast  = in_last;
            if (mm2s_tvalid && core_in_tready) begin
              in_cnt_d = in_cnt_q + LEN_ONE;
              // The frame length stays authoritative; a wrong tlast only flags.
              if (mm2s_tlast != in_last) begin
                err_tlast_d = 1'b1;
              end
            end
          end
          if (out_cnt_q < out_len_q) begin
            out_last        = (out_cnt_q == out_len_q - LEN_ONE);
            s2mm_tvalid     = core_out_tvalid;
            core_out_tready = s2mm_tready;
            s2mm_tdata      = core_out_tdata;
            s2mm_tlast      = out_last;
            if (core_out_tvalid && s2mm_tready) begin
              out_cnt_d = out_cnt_q + LEN_ONE;
            end
          end
          if (in_cnt_d == in_len_q && out_cnt_d == out_len_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        frame_count_d = frame_count_q + FCNT_ONE;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= IDLE;
      in_len_q      <= '0;
      out_len_q     <= '0;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      err_tlast_q   <= 1'b0;
      err_cfg_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      in_len_q      <= in_len_d;
      out_len_q     <= out_len_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      err_tlast_q   <= err_tlast_d;
      err_cfg_q     <= err_cfg_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err_cfg     = err_cfg_q;
  assign err_tlast   = err_tlast_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_stream_frame_ctrl.sv
// Self-checking bench for stream_frame_ctrl: MM2S FIFO model, core result generator,
// and scoreboard queues of expected core-input and S2MM words.
module tb_stream_frame_ctrl;

  localparam int DW = 16;
  localparam int LW = 10;
  localparam int FW = 16;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_abort = 1'b0;
  logic [LW-1:0] cfg_in_len = '0;
  logic [LW-1:0] cfg_out_len = '0;
  logic [DW-1:0] mm2s_tdata = '0;
  logic          mm2s_tvalid = 1'b0;
  logic          mm2s_tlast = 1'b0;
  logic [LW-1:0] mm2s_data_count = '0;
  logic          mm2s_tready;
  logic [DW-1:0] core_in_tdata;
  logic          core_in_tvalid;
  logic          core_in_tlast;
  logic          core_in_tready = 1'b0;
  logic [DW-1:0] core_out_tdata = '0;
  logic          core_out_tvalid = 1'b0;
  logic          core_out_tready;
  logic [DW-1:0] s2mm_tdata;
  logic          s2mm_tvalid;
  logic          s2mm_tlast;
  logic          s2mm_tready = 1'b0;
  logic          busy;
  logic          done;
  logic          err_cfg;
  logic          err_tlast;
  logic [FW-1:0] frame_count;

  always #5 aclk = ~aclk;

  stream_frame_ctrl #(.DATA_WIDTH(DW), .LEN_W(LW), .FCNT_W(FW)) dut (
    .aclk(aclk), .areset(areset),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_in_len(cfg_in_len), .cfg_out_len(cfg_out_len),
    .mm2s_tdata(mm2s_tdata), .mm2s_tvalid(mm2s_tvalid), .mm2s_tlast(mm2s_tlast),
    .mm2s_data_count(mm2s_data_count), .mm2s_tready(mm2s_tready),
    .core_in_tdata(core_in_tdata), .core_in_tvalid(core_in_tvalid),
    .core_in_tlast(core_in_tlast), .core_in_tready(core_in_tready),
    .core_out_tdata(core_out_tdata), .core_out_tvalid(core_out_tvalid),
    .core_out_tready(core_out_tready),
    .s2mm_tdata(s2mm_tdata), .s2mm_tvalid(s2mm_tvalid), .s2mm_tlast(s2mm_tlast),
    .s2mm_tready(s2mm_tready),
    .busy(busy), .done(done), .err_cfg(err_cfg), .err_tlast(err_tlast),
    .frame_count(frame_count)
  );

  int total = 0;
  int bad = 0;

  logic [DW:0] fifo_q[$];   // {tlast, data} held in the MM2S FIFO model
  logic [DW:0] exp_in[$];   // expected {core_in_tlast, core_in_tdata}
  logic [DW:0] exp_out[$];  // expected {s2mm_tlast, s2mm_tdata}
  int          gen_idx = 0;
  bit          gen_on = 1'b0;
  bit          rand_mode = 1'b0;
  int          done_cnt = 0;
  int          exp_fc = 0;
  int          frame_no = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive all model-owned inputs from the current model state.
  task automatic drive();
    mm2s_data_count = LW'(fifo_q.size());
    mm2s_tvalid     = (fifo_q.size() > 0);
    {mm2s_tlast, mm2s_tdata} = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    core_in_tready  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    s2mm_tready     = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    core_out_tvalid = gen_on && (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    core_out_tdata  = 16'hC000 + 16'(gen_idx);
  endtask

  // Observe handshakes that complete at the coming clock edge.
  task automatic sample();
    logic [DW:0] e;
    if (mm2s_tvalid && mm2s_tready && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (core_in_tvalid && core_in_tready) begin
      check_val("in_expected", 32'(exp_in.size() != 0), 32'd1);
      if (exp_in.size() != 0) begin
        e = exp_in.pop_front();
        check_val("in_data", 32'(core_in_tdata), 32'(e[DW-1:0]));
        check_val("in_last", 32'(core_in_tlast), 32'(e[DW]));
      end
    end
    if (s2mm_tvalid && s2mm_tready) begin
      check_val("out_expected", 32'(exp_out.size() != 0), 32'd1);
      if (exp_out.size() != 0) begin
        e = exp_out.pop_front();
        check_val("out_data", 32'(s2mm_tdata), 32'(e[DW-1:0]));
        check_val("out_last", 32'(s2mm_tlast), 32'(e[DW]));
      end
    end
    if (core_out_tvalid && core_out_tready) gen_idx++;
    if (done) done_cnt++;
  endtask

  task automatic sample_and_advance();
    sample();
    @(posedge aclk);
    #1;
    drive();
  endtask

  task automatic step();
    @(negedge aclk);
    sample_and_advance();
  endtask

  task automatic preload(input int n, input int base, input int src_last_idx);
    for (int k = 0; k < n; k++) begin
      fifo_q.push_back({1'(k == src_last_idx), 16'(base + k)});
      exp_in.push_back({1'(k == n - 1), 16'(base + k)});
    end
  endtask

  task automatic start(input int in_len, input int out_len, input bit expect_ok);
    cfg_in_len  = LW'(in_len);
    cfg_out_len = LW'(out_len);
    if (expect_ok) begin
      for (int k = 0; k < out_len; k++) exp_out.push_back({1'(k == out_len - 1), 16'hC000 + 16'(k)});
      gen_idx = 0;
      gen_on  = 1'b1;
    end
    cfg_start = 1'b1;
    drive();
    step();
    cfg_start = 1'b0;
  endtask

  task automatic finish_frame(input string name, input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) step();
    step();
    step();
    exp_fc++;
    check_val({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check_val({name, "_in_left"}, 32'(exp_in.size()), 32'd0);
    check_val({name, "_out_left"}, 32'(exp_out.size()), 32'd0);
    check_val({name, "_fcount"}, 32'(frame_count), 32'(exp_fc));
    check_val({name, "_busy"}, 32'(busy), 32'd0);
    frame_no++;
    $display("frame %0d %s complete at %0t, frame_count=%0d", frame_no, name, $time, frame_count);
  endtask

  task automatic flush();
    fifo_q.delete();
    exp_in.delete();
    exp_out.delete();
    gen_on = 1'b0;
    drive();
  endtask

  task automatic check_idle_outputs(input string name);
    check_val({name, "_busy"}, 32'(busy), 32'd0);
    check_val({name, "_done"}, 32'(done), 32'd0);
    check_val({name, "_mm2s_rdy"}, 32'(mm2s_tready), 32'd0);
    check_val({name, "_cin_vld"}, 32'(core_in_tvalid), 32'd0);
    check_val({name, "_cout_rdy"}, 32'(core_out_tready), 32'd0);
    check_val({name, "_s2mm_vld"}, 32'(s2mm_tvalid), 32'd0);
  endtask

  initial begin
    int d0;
    // Reset state.
    drive();
    repeat (3) step();
    @(negedge aclk);
    check_idle_outputs("rst");
    check_val("rst_err_cfg", 32'(err_cfg), 32'd0);
    check_val("rst_err_tlast", 32'(err_tlast), 32'd0);
    check_val("rst_fcount", 32'(frame_count), 32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    step();

    // Basic frame: 8 in, 4 out.
    preload(8, 1, 7);
    drive();
    start(8, 4, 1'b1);
    finish_frame("basic", 200);
    check_val("basic_err_tlast", 32'(err_tlast), 32'd0);

    // Fill wait: 10 of 16 words present, then the remaining 6 arrive.
    preload(16, 16'h100, 15);
    for (int k = 0; k < 6; k++) void'(fifo_q.pop_back());
    drive();
    start(16, 2, 1'b1);
    repeat (6) step();
    check_val("fill_hold_cnt", 32'(fifo_q.size()), 32'd10);
    check_val("fill_busy", 32'(busy), 32'd1);
    for (int k = 10; k < 16; k++) fifo_q.push_back({1'(k == 15), 16'h100 + 16'(k)});
    drive();
    @(negedge aclk);
    check_val("fill_pre_run_rdy", 32'(mm2s_tready), 32'd0);
    sample_and_advance();
    @(negedge aclk);
    check_val("fill_run_rdy", 32'(mm2s_tready), 32'd1);
    sample_and_advance();
    finish_frame("fill", 200);

    // Random back-pressure on every handshake, 32 words each way.
    rand_mode = 1'b1;
    preload(32, 16'h200, 31);
    drive();
    start(32, 32, 1'b1);
    finish_frame("bp", 2000);
    rand_mode = 1'b0;
    drive();

    // Source tlast on word 2 of 4: flagged, frame still consumes 4 words.
    preload(4, 16'h300, 1);
    drive();
    start(4, 2, 1'b1);
    finish_frame("tlast", 200);
    check_val("tlast_err_set", 32'(err_tlast), 32'd1);
    repeat (3) step();
    check_val("tlast_err_sticky", 32'(err_tlast), 32'd1);
    preload(2, 16'h400, 1);
    drive();
    start(2, 1, 1'b1);
    check_val("tlast_err_cleared", 32'(err_tlast), 32'd0);
    finish_frame("clear", 200);

    // Rejected configurations and the 512-word boundary.
    start(8, 0, 1'b0);
    check_val("cfg_out0_err", 32'(err_cfg), 32'd1);
    check_val("cfg_out0_busy", 32'(busy), 32'd0);
    step();
    check_val("cfg_err_pulse", 32'(err_cfg), 32'd0);
    start(0, 4, 1'b0);
    check_val("cfg_in0_err", 32'(err_cfg), 32'd1);
    start(513, 4, 1'b0);
    check_val("cfg_513_err", 32'(err_cfg), 32'd1);
    check_val("cfg_513_busy", 32'(busy), 32'd0);
    start(512, 1, 1'b0);
    check_val("cfg_512_err", 32'(err_cfg), 32'd0);
    check_val("cfg_512_busy", 32'(busy), 32'd1);
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    check_val("cfg_512_abort_busy", 32'(busy), 32'd0);

    // Abort mid-RUN after 3 of 8 words.
    preload(8, 16'h500, 7);
    drive();
    start(8, 4, 1'b1);
    for (int i = 0; i < 50 && exp_in.size() > 5; i++) step();
    check_val("abort_consumed", 32'(exp_in.size()), 32'd5);
    d0 = done_cnt;
    cfg_abort = 1'b1;
    @(negedge aclk);
    check_val("abort_mm2s_rdy", 32'(mm2s_tready), 32'd0);
    check_val("abort_cin_vld", 32'(core_in_tvalid), 32'd0);
    check_val("abort_s2mm_vld", 32'(s2mm_tvalid), 32'd0);
    check_val("abort_cout_rdy", 32'(core_out_tready), 32'd0);
    sample_and_advance();
    cfg_abort = 1'b0;
    check_val("abort_busy", 32'(busy), 32'd0);
    repeat (3) step();
    check_val("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check_val("abort_fcount", 32'(frame_count), 32'(exp_fc));
    check_val("abort_fifo_kept", 32'(fifo_q.size()), 32'd5);
    $display("frame aborted at %0t, frame_count=%0d", $time, frame_count);
    flush();

    // Reset in the middle of RUN, then a clean frame.
    preload(8, 16'h600, 7);
    drive();
    start(8, 4, 1'b1);
    for (int i = 0; i < 50 && exp_in.size() > 6; i++) step();
    areset = 1'b1;
    step();
    areset = 1'b0;
    @(negedge aclk);
    check_idle_outputs("mid_rst");
    check_val("mid_rst_fcount", 32'(frame_count), 32'd0);
    check_val("mid_rst_err_tlast", 32'(err_tlast), 32'd0);
    $display("reset applied mid-frame at %0t", $time);
    @(posedge aclk);
    #1;
    flush();
    exp_fc = 0;
    preload(4, 16'h700, 3);
    drive();
    start(4, 3, 1'b1);
    finish_frame("post_rst", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
